// File: rtl/float_alu_pkg.sv
// float_alu_pkg
// Shared definitions for the single-precision ALU datapath: flag bit
// positions, word widths, the default result-FIFO depth, the packed
// result-entry layout and the occupancy-state encoding. The multiplier-side
// glue and the result FIFO both import this package.
package float_alu_pkg;

  // Bit positions inside a 4-bit flag vector {exception, overflow, underflow, zero}
  localparam int FLAG_EXC  = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  localparam int FLAG_W  = 4;
  localparam int FP_W    = 32;
  localparam int ENTRY_W = FLAG_W + FP_W;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // One buffered multiplier result; flags occupy the upper bits
  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [FP_W-1:0]   product;
  } result_entry_t;

  // Occupancy of the result FIFO, derived purely from its count
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // A result counts as an error event when any of exception, overflow or
  // underflow is raised; a zero result on its own is not an error.
  function automatic logic is_error(input logic [FLAG_W-1:0] flags);
    return flags[FLAG_EXC] | flags[FLAG_OVF] | flags[FLAG_UNF];
  endfunction

endpackage

// File: rtl/float_result_fifo_mem.sv
// float_result_fifo_mem
// DEPTH x 36-bit storage array for the result FIFO.
// Ports:
//   clk      - rising-edge clock for the write port
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - result entry to store
//   rd_addr  - read index (asynchronous read)
//   rd_data  - entry at rd_addr
module float_result_fifo_mem
  import float_alu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  result_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output result_entry_t rd_data
);

  result_entry_t mem [DEPTH];

  // Storage is not reset: validity is tracked by the pointers and count
  // in the parent, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/float_result_fifo.sv
// float_result_fifo
// Registered capture stage behind the combinational FP multiplier. Buffers
// product words plus their four status flags in a DEPTH-entry FIFO and keeps
// sticky flags and a saturating error-event counter for software polling.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in_valid / in_ready       - producer handshake (in_ready = !full)
//   in_product, in_exception, in_overflow, in_underflow, in_zero - result
//   out_valid / out_ready     - consumer handshake (out_valid = !empty)
//   out_product, out_flags    - head entry, zero when empty
//   count                     - current occupancy 0..DEPTH
//   sticky_flags              - OR of flags of all accepted entries
//   err_count                 - saturating count of erroring entries
//   sticky_clr                - synchronous clear of sticky_flags/err_count
module float_result_fifo
  import float_alu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   in_product,
  input  logic              in_exception,
  input  logic              in_overflow,
  input  logic              in_underflow,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_product,
  output logic [FLAG_W-1:0] out_flags,
  output logic [CNT_W-1:0]  count,
  output logic [FLAG_W-1:0] sticky_flags,
  output logic [7:0]        err_count,
  input  logic              sticky_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              push;
  logic              pop;
  logic [FLAG_W-1:0] in_flags;
  result_entry_t     wr_entry;
  result_entry_t     rd_entry;
  occ_state_t        occ_state;
  logic [FLAG_W-1:0] next_sticky;
  logic [7:0]        err_base;
  logic [7:0]        next_err;

  assign in_flags = {in_exception, in_overflow, in_underflow, in_zero};
  assign wr_entry = '{flags: in_flags, product: in_product};

  // Occupancy classification from count alone, so the handshake outputs
  // never depend combinationally on any input.
  always_comb begin
    occ_state = OCC_PARTIAL;
    if (count == '0) begin
      occ_state = OCC_EMPTY;
    end else if (count == CNT_W'(DEPTH)) begin
      occ_state = OCC_FULL;
    end
  end

  assign in_ready  = (occ_state != OCC_FULL);
  assign out_valid = (occ_state != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  float_result_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wp),
    .wr_data (wr_entry),
    .rd_addr (rp),
    .rd_data (rd_entry)
  );

  // Empty FIFO shows zeros rather than whatever stale word rp points at
  assign out_product = out_valid ? rd_entry.product : '0;
  assign out_flags   = out_valid ? rd_entry.flags   : '0;

  // Pointers wrap modulo DEPTH by overflow; count disambiguates full/empty.
  // Simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear is applied before the OR/increment so a same-cycle push survives
  // the clear.
  always_comb begin
    next_sticky = (sticky_clr ? '0 : sticky_flags) | (push ? in_flags : '0);
    err_base    = sticky_clr ? 8'd0 : err_count;
    next_err    = err_base;
    if (push && is_error(in_flags) && (err_base != 8'hFF)) begin
      next_err = err_base + 8'd1;
    end
  end

  // Status registers for software polling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
      err_count    <= '0;
    end else begin
      sticky_flags <= next_sticky;
      err_count    <= next_err;
    end
  end

endmodule

// File: tb/tb_float_result_fifo.sv
// tb_float_result_fifo
// Self-checking bench for float_result_fifo (DEPTH=4). Directed stimulus
// with hand-computed expectations; a negedge monitor keeps an expected-entry
// queue plus sticky/error models and compares every DUT output each cycle.
module tb_float_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_product = '0;
  logic             in_exception = 1'b0;
  logic             in_overflow = 1'b0;
  logic             in_underflow = 1'b0;
  logic             in_zero = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_product;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] count;
  logic [3:0]       sticky_flags;
  logic [7:0]       err_count;
  logic             sticky_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [3:0]  m_sticky = '0;
  logic [7:0]  m_err = '0;
  int          m_sz;
  logic        m_push;
  logic        m_pop;
  logic [3:0]  m_flags;

  float_result_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_exception (in_exception),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .err_count    (err_count),
    .sticky_clr   (sticky_clr)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that acts on them
  task automatic applyStimulus(input logic v, input logic [31:0] prod, input logic [3:0] flags,
                               input logic rdy, input logic clr);
    in_valid     = v;
    in_product   = prod;
    in_exception = flags[3];
    in_overflow  = flags[2];
    in_underflow = flags[1];
    in_zero      = flags[0];
    out_ready    = rdy;
    sticky_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: compares DUT state with the model, then advances
  // the model by the push/pop the coming edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sticky = '0;
      m_err    = '0;
      checkOutput("mon_rst_count", 36'(count), 36'd0);
      checkOutput("mon_rst_out_valid", 36'(out_valid), 36'd0);
    end else begin
      m_sz = exp_q.size();
      checkOutput("mon_count", 36'(count), 36'(m_sz));
      checkOutput("mon_out_valid", 36'(out_valid), 36'(m_sz != 0));
      checkOutput("mon_in_ready", 36'(in_ready), 36'(m_sz < DEPTH));
      if (m_sz != 0) checkOutput("mon_head", {out_flags, out_product}, exp_q[0]);
      else           checkOutput("mon_empty_data", {out_flags, out_product}, 36'd0);
      checkOutput("mon_sticky", 36'(sticky_flags), 36'(m_sticky));
      checkOutput("mon_err_count", 36'(err_count), 36'(m_err));

      m_flags = {in_exception, in_overflow, in_underflow, in_zero};
      m_push  = in_valid && (m_sz < DEPTH);
      m_pop   = (m_sz != 0) && out_ready;
      if (sticky_clr) begin
        m_sticky = '0;
        m_err    = '0;
      end
      if (m_push) begin
        m_sticky = m_sticky | m_flags;
        if ((m_flags[3] | m_flags[2] | m_flags[1]) && m_err != 8'hFF) m_err = m_err + 8'd1;
      end
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({m_flags, in_product});
    end
  end

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_count", 36'(count), 36'd0);
    checkOutput("reset_in_ready", 36'(in_ready), 36'd1);
    checkOutput("reset_out_valid", 36'(out_valid), 36'd0);
    checkOutput("reset_out_data", {out_flags, out_product}, 36'd0);
    checkOutput("reset_sticky", 36'(sticky_flags), 36'd0);
    checkOutput("reset_err", 36'(err_count), 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single push of 3.0, visible one cycle later
    applyStimulus(1'b1, 32'h4040_0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("first_out_valid", 36'(out_valid), 36'd1);
    checkOutput("first_product", 36'(out_product), 36'h0_4040_0000);
    checkOutput("first_flags", 36'(out_flags), 36'd0);
    checkOutput("first_count", 36'(count), 36'd1);
    checkOutput("first_sticky", 36'(sticky_flags), 36'd0);
    checkOutput("first_err", 36'(err_count), 36'd0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    checkOutput("first_drained", 36'(count), 36'd0);

    // Fill to DEPTH, fifth push ignored, drain in order
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h3F80_0000 + 32'(i), 4'b0000, 1'b0, 1'b0);
    checkOutput("full_count", 36'(count), 36'd4);
    checkOutput("full_in_ready", 36'(in_ready), 36'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0);
    checkOutput("full_ignored_count", 36'(count), 36'd4);
    checkOutput("full_head", 36'(out_product), 36'h0_3F80_0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    checkOutput("drain_count", 36'(count), 36'd0);
    checkOutput("drain_product", 36'(out_product), 36'd0);
    checkOutput("drain_out_valid", 36'(out_valid), 36'd0);

    // Steady push+pop at count 2 across pointer wrap
    applyStimulus(1'b1, 32'hA000_0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA000_0001, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'hA000_0002 + 32'(i), 4'b0000, 1'b1, 1'b0);
    checkOutput("stream_count", 36'(count), 36'd2);
    checkOutput("stream_head", 36'(out_product), 36'h0_A000_0014);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // Sticky flags and error counting, then clear with concurrent push
    applyStimulus(1'b1, 32'h1111_0000, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1111_0001, 4'b0100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1111_0002, 4'b0001, 1'b0, 1'b0);
    checkOutput("sticky_or", 36'(sticky_flags), 36'b1101);
    checkOutput("err_two", 36'(err_count), 36'd2);
    applyStimulus(1'b1, 32'h1111_0003, 4'b0010, 1'b0, 1'b1);
    checkOutput("sticky_clr_push", 36'(sticky_flags), 36'b0010);
    checkOutput("err_clr_push", 36'(err_count), 36'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 32'(i), 4'b0100, 1'b1, 1'b0);
    checkOutput("err_saturated", 36'(err_count), 36'd255);
    checkOutput("sticky_after_sat", 36'(sticky_flags), 36'b0110);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
    checkOutput("clr_sticky", 36'(sticky_flags), 36'd0);
    checkOutput("clr_err", 36'(err_count), 36'd0);
    applyStimulus(1'b1, 32'h0000_0000, 4'b0001, 1'b1, 1'b0);
    checkOutput("zero_no_err", 36'(err_count), 36'd0);
    checkOutput("zero_sticky", 36'(sticky_flags), 36'b0001);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset between edges discards contents immediately
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hBEEF_0000 + 32'(i), 4'b1000, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", 36'(out_valid), 36'd0);
    checkOutput("async_count", 36'(count), 36'd0);
    checkOutput("async_in_ready", 36'(in_ready), 36'd1);
    checkOutput("async_sticky", 36'(sticky_flags), 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 32'hC000_0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("post_reset_head", 36'(out_product), 36'h0_C000_0000);
    checkOutput("post_reset_count", 36'(count), 36'd1);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_result_fifo.md
# float_result_fifo

Registered result-capture stage placed directly downstream of the combinational single-precision multiplier in the IEEE-754 ALU. It accepts each product word and its four status flags under a valid/ready handshake, and buffers them in a DEPTH-entry FIFO. It presents them to the consumer under a second valid/ready handshake. It also keeps IEEE-style sticky status flags and a saturating error-event counter for software polling.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  multiplier result valid.
- in_ready  out  1  stage can accept; equals !full.
- in_product  in  32  multiplier product word.
- in_exception, in_overflow, in_underflow, in_zero  in  1 each  multiplier flags.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer accepts head.
- out_product  out  32  head product; 32'd0 when empty.
- out_flags  out  4  head flags {exception, overflow, underflow, zero}; 4'd0 when empty.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- sticky_flags  out  4  OR of flags of all accepted entries since last clear, same bit order.
- err_count  out  8  accepted entries with exception|overflow|underflow set; saturates at 8'hFF.
- sticky_clr  in  1  synchronous clear of sticky_flags and err_count.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- Entry = {in_exception, in_overflow, in_underflow, in_zero, in_product}, 36 bits.
- Write pointer wp and read pointer rp are log2(DEPTH)-bit. They wrap modulo DEPTH naturally; count tracks fullness.
- Occupancy state, derived from count:
  - EMPTY (count==0): push goes to PARTIAL, or to FULL if DEPTH==1 is not allowed.
  - PARTIAL: push-only increments count; pop-only decrements it; push+pop holds count and advances both pointers.
  - FULL (count==DEPTH): in_ready=0, so push is impossible. Pop moves to PARTIAL. There is no same-cycle push-through when full.
- Empty: out_valid=0 and out_product/out_flags are forced to 0. An input is never bypassed to the output in the same cycle.
- Data is never dropped or reordered. in_valid while in_ready=0 has no effect, and the producer must hold its data.
- Sticky update:
  - next_sticky = (sticky_clr ? 0 : sticky) | (push ? in_flags : 0).
  - A clear and a push in the same cycle leave the pushed flags set.
- err_count update:
  - next = (sticky_clr ? 0 : err_count) + (push & (in_exception|in_overflow|in_underflow)).
  - Saturates at 255. A clear plus an erroring push yields 1.
- in_zero alone does not increment err_count.

## Timing
- Reset values: wp=0, rp=0, count=0, in_ready=1, out_valid=0, out_product=0, out_flags=0, sticky_flags=0, err_count=0.
- Asserting rst mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed on edge N is visible at out_* after edge N (one cycle), provided all earlier entries have been popped.
- Throughput: one push and one pop per cycle in PARTIAL.
- in_ready and out_valid are combinational functions of count only, with no input-to-output combinational path.
- count, sticky_flags and err_count update on the same edge as the push/pop that causes them.

## Structure
- Shared package float_alu_pkg holds:
  - FLAG_EXC=3, FLAG_OVF=2, FLAG_UNF=1, FLAG_ZERO=0.
  - FLAG_W=4, FP_W=32.
  - The default FIFO depth constant.
  The multiplier-side glue uses the same package.
- One sub-module is natural: float_result_fifo_mem, a DEPTH x 36 register array with a synchronous write port and an asynchronous read port.
- Pointer, count, handshake and sticky/counter logic stay in the top module.

## Test plan
- Reset, then push 0x40400000 (3.0) with flags 0000 → out_valid=1 the next cycle, out_product=0x40400000, out_flags=0, count=1, sticky=0, err_count=0.
- Hold out_ready=0 and push 4 words 0x3F800000..0x3F800003 (DEPTH=4) → count=4, in_ready=0. A fifth in_valid is ignored. Then pop 4 → words come out in order, ending with count=0 and out_product=0.
- Keep the FIFO at count=2 and drive push+pop every cycle for 20 cycles with pointer wrap → count stays 2 and the data sequence is preserved.
- Push entries with flags 1000, 0100, 0001 → sticky=1101 and err_count=2. Then sticky_clr together with a push of flags 0010 → sticky=0010, err_count=1.
- Push 300 entries with overflow set while popping continuously → err_count saturates at 255.
- Fill 3 entries, then assert rst asynchronously between edges → out_valid=0, count=0 and in_ready=1 immediately. After release, the first push of 0xC0000000 appears as the head.
